div_ratio_ctrl: RTL and testbench
=================================

DIV_RATIO_CTRL -- requirements
Module: div_ratio_ctrl

Interface
REQ-001 The block SHALL have parameter CW, default 4, which sets the ratio and counter width in bits.
REQ-002 The block SHALL have parameter DEF_N, default 5, which sets the divide ratio loaded at reset; legal range is 2..2^CW-1.
REQ-003 Port clkin  input  1  single clock; all flops SHALL be clocked on its posedge only.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port req_a / req_b  input  1 each  ratio-change request from requester A / B; held high until the matching ack.
REQ-006 Port n_a / n_b  input  CW each  requested divide ratio; stable while the matching req is high.
REQ-007 Port ack_a / ack_b  output  1 each  one-cycle completion pulse to requester A / B.
REQ-008 Port err  output  1  one-cycle pulse, coincident with ack, when the request was rejected.
REQ-009 Port busy  output  1  high while a granted change is pending.
REQ-010 Port cur_n  output  CW  divide ratio currently in effect.
REQ-011 Port clkout  output  1  registered divided clock.
REQ-012 Port tick  output  1  one-cycle pulse marking the start of each output period.

Function
REQ-013 The phase counter cnt SHALL count 0..cur_n-1 and wrap to 0; the wrap edge is the edge where cnt==cur_n-1.
REQ-014 clkout SHALL be registered as clkout <= (cnt_next < (cur_n_next>>1)): high for floor(N/2) of every N cycles, no combinational path to the output.
REQ-015 tick SHALL be registered high for exactly one cycle after each wrap edge.
REQ-016 The FSM SHALL have two states: IDLE and PEND.
REQ-017 In IDLE, a requester whose ack is high in the current cycle SHALL be ignored.
REQ-018 In IDLE, with one eligible req, that requester SHALL be granted; with both eligible, the one not granted last SHALL win (round-robin).
REQ-019 On a grant with n in 2..2^CW-1, pend_n SHALL capture n, the FSM SHALL go to PEND and busy SHALL be 1 from the next cycle.
REQ-020 On a grant with n<2, the FSM SHALL stay in IDLE, the matching ack and err SHALL pulse the next cycle and cur_n SHALL be unchanged; last_grant SHALL still update.
REQ-021 In PEND, new requests SHALL be held off: no grant and no ack.
REQ-022 In PEND, on the wrap edge, cur_n SHALL take pend_n, cnt SHALL go to 0, the matching ack SHALL pulse the next cycle, busy SHALL drop and the FSM SHALL return to IDLE.
REQ-023 The new ratio SHALL therefore take effect only at a period boundary, giving glitch-free switching with no truncated high phase.
REQ-024 If a grant occurs on the wrap edge itself, the change SHALL wait for the following wrap, completing within cur_n+1 cycles.
REQ-025 Worst-case latency from req to ack SHALL be 1 + cur_n + 1 cycles.
REQ-026 A requester that keeps req high for one cycle after its ack SHALL NOT be regranted for that cycle (REQ-017); req still high in the cycle after that SHALL count as a new request.
REQ-027 Requesting the ratio already in effect SHALL be handled as a normal change: wait for wrap, then ack.
REQ-028 ack_a and ack_b SHALL never be high in the same cycle.
REQ-029 All arithmetic SHALL be unsigned CW-bit; cnt SHALL never exceed cur_n-1.

Reset
REQ-030 While rst=1, the block SHALL hold: cnt=0, cur_n=DEF_N, pend_n=DEF_N, clkout=0, tick=0, ack_a=ack_b=0, err=0, busy=0, FSM=IDLE, last_grant=B (A wins the first tie).
REQ-031 Reset asserted mid-PEND SHALL abort the pending change with no ack issued.
REQ-032 After rst deasserts, the first posedge SHALL give cnt=1 and clkout=1 for DEF_N=5.

Verification
REQ-033 Free run, no requests, DEF_N=5: clkout SHALL give a repeating 1,1,0,0,0 pattern; tick SHALL pulse every 5 cycles; cur_n SHALL stay 5.
REQ-034 req_a with n_a=4, asserted when cnt=1: busy SHALL go to 1, ack_a SHALL pulse one cycle after the wrap edge, cur_n SHALL be 4, and clkout SHALL then repeat 1,1,0,0 with no short pulse at the switch.
REQ-035 req_a and req_b raised in the same cycle after reset (n_a=3, n_b=7): A SHALL be served first (cur_n=3), then B (cur_n=7); the acks SHALL be in separate cycles with no err.
REQ-036 req_b with n_b=1: ack_b and err SHALL pulse together 2 cycles after req, cur_n SHALL stay unchanged and busy SHALL stay 0.
REQ-037 rst pulsed while in PEND with pend_n=9: no ack SHALL occur, cur_n SHALL return to 5, and outputs SHALL match REQ-030.
REQ-038 req_a held high across its ack: no regrant SHALL occur in the ack cycle; if still high on the next cycle, a second grant SHALL be observed.

Source files
------------

// File: rtl/div_ratio_ctrl.sv
// div_ratio_ctrl: programmable clock divider with two-requester, round-robin
// ratio change control. A new ratio is applied only at a period boundary so
// the output clock never sees a truncated high phase.
module div_ratio_ctrl #(
    parameter int unsigned CW    = 4,
    parameter int unsigned DEF_N = 5
) (
    input  logic          clkin,
    input  logic          rst,
    input  logic          req_a,
    input  logic          req_b,
    input  logic [CW-1:0] n_a,
    input  logic [CW-1:0] n_b,
    output logic          ack_a,
    output logic          ack_b,
    output logic          err,
    output logic          busy,
    output logic [CW-1:0] cur_n,
    output logic          clkout,
    output logic          tick
);

    localparam logic [CW-1:0] RST_N = CW'(DEF_N);
    localparam logic [CW-1:0] MIN_N = CW'(2);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [CW-1:0] cnt;
    logic [CW-1:0] pend_n;
    logic          last_grant;   // 0: A granted last, 1: B granted last
    logic          pend_sel;     // requester owning the pending change

    logic          wrap_c;
    logic          elig_a_c;
    logic          elig_b_c;
    logic          grant_any_c;
    logic          grant_sel_c;
    logic [CW-1:0] grant_n_c;
    logic          grant_ok_c;

    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cur_n_d;
    logic [CW-1:0] pend_n_d;
    logic          last_grant_d;
    logic          pend_sel_d;
    logic          ack_a_d;
    logic          ack_b_d;
    logic          err_d;
    logic          busy_d;
    logic          clkout_d;
    logic          tick_d;

    // Arbitration: a requester acked this cycle is not eligible; ties go to
    // whoever was not granted last.
    always_comb begin
        wrap_c      = (cnt == (cur_n - CW'(1)));
        elig_a_c    = req_a & ~ack_a;
        elig_b_c    = req_b & ~ack_b;
        grant_any_c = (state == IDLE) & (elig_a_c | elig_b_c);
        grant_sel_c = (elig_a_c & elig_b_c) ? ~last_grant : elig_b_c;
        grant_n_c   = grant_sel_c ? n_b : n_a;
        grant_ok_c  = (grant_n_c >= MIN_N);
    end

    // State register
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (grant_any_c && grant_ok_c) state_next = PEND;
            PEND: if (wrap_c) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output/datapath next values; everything below is registered
    always_comb begin
        cnt_d        = wrap_c ? '0 : (cnt + CW'(1));
        cur_n_d      = cur_n;
        pend_n_d     = pend_n;
        last_grant_d = last_grant;
        pend_sel_d   = pend_sel;
        ack_a_d      = 1'b0;
        ack_b_d      = 1'b0;
        err_d        = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any_c) begin
                    last_grant_d = grant_sel_c;
                    if (grant_ok_c) begin
                        pend_n_d   = grant_n_c;
                        pend_sel_d = grant_sel_c;
                    end else begin
                        ack_a_d = ~grant_sel_c;
                        ack_b_d = grant_sel_c;
                        err_d   = 1'b1;
                    end
                end
            end
            PEND: begin
                if (wrap_c) begin
                    cur_n_d = pend_n;
                    ack_a_d = ~pend_sel;
                    ack_b_d = pend_sel;
                end
            end
            default: ;
        endcase
        clkout_d = (cnt_d < (cur_n_d >> 1));
        tick_d   = wrap_c;
        busy_d   = (state_next == PEND);
    end

    // Datapath and output registers
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            cur_n      <= RST_N;
            pend_n     <= RST_N;
            last_grant <= 1'b1;
            pend_sel   <= 1'b0;
            ack_a      <= 1'b0;
            ack_b      <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
            clkout     <= 1'b0;
            tick       <= 1'b0;
        end else begin
            cnt        <= cnt_d;
            cur_n      <= cur_n_d;
            pend_n     <= pend_n_d;
            last_grant <= last_grant_d;
            pend_sel   <= pend_sel_d;
            ack_a      <= ack_a_d;
            ack_b      <= ack_b_d;
            err        <= err_d;
            busy       <= busy_d;
            clkout     <= clkout_d;
            tick       <= tick_d;
        end
    end

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Directed bench for div_ratio_ctrl with hand-computed expectations.
module tb_div_ratio_ctrl;

    localparam int unsigned CW = 4;

    logic          clkin;
    logic          rst;
    logic          req_a;
    logic          req_b;
    logic [CW-1:0] n_a;
    logic [CW-1:0] n_b;
    logic          ack_a;
    logic          ack_b;
    logic          err;
    logic          busy;
    logic [CW-1:0] cur_n;
    logic          clkout;
    logic          tick;

    int n_cmp = 0;
    int n_bad = 0;

    div_ratio_ctrl #(.CW(CW), .DEF_N(5)) dut (
        .clkin  (clkin),
        .rst    (rst),
        .req_a  (req_a),
        .req_b  (req_b),
        .n_a    (n_a),
        .n_b    (n_b),
        .ack_a  (ack_a),
        .ack_b  (ack_b),
        .err    (err),
        .busy   (busy),
        .cur_n  (cur_n),
        .clkout (clkout),
        .tick   (tick)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    task automatic step();
        @(posedge clkin);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [9:0] exp_clk10;
        logic [9:0] exp_tick10;
        logic [7:0] exp_clk8;
        logic [7:0] exp_tick8;

        rst   = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        n_a   = '0;
        n_b   = '0;

        // Reset state
        repeat (3) step();
        chk("rst_cur_n", 32'(cur_n), 32'd5);
        chk("rst_clkout", 32'(clkout), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_ack_a", 32'(ack_a), 32'd0);
        chk("rst_ack_b", 32'(ack_b), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Free run at N=5: first edge gives clkout=1, then 1,1,0,0,0 cadence
        rst = 1'b0;
        exp_clk10  = 10'b1000110001;
        exp_tick10 = 10'b0000100001;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("free_clkout_%0d", i), 32'(clkout), 32'(exp_clk10[9-i]));
            chk($sformatf("free_tick_%0d", i), 32'(tick), 32'(exp_tick10[9-i]));
            chk($sformatf("free_cur_n_%0d", i), 32'(cur_n), 32'd5);
            chk($sformatf("free_busy_%0d", i), 32'(busy), 32'd0);
        end

        // Change to N=4 requested at cnt=1
        step();
        chk("a4_pre_clkout", 32'(clkout), 32'd1);
        req_a = 1'b1;
        n_a   = 4'd4;
        step();
        chk("a4_busy_1", 32'(busy), 32'd1);
        chk("a4_noack_1", 32'(ack_a), 32'd0);
        chk("a4_clkout_1", 32'(clkout), 32'd0);
        step();
        chk("a4_busy_2", 32'(busy), 32'd1);
        step();
        chk("a4_busy_3", 32'(busy), 32'd1);
        chk("a4_noack_3", 32'(ack_a), 32'd0);
        step();
        chk("a4_ack", 32'(ack_a), 32'd1);
        chk("a4_ack_b", 32'(ack_b), 32'd0);
        chk("a4_err", 32'(err), 32'd0);
        chk("a4_busy_done", 32'(busy), 32'd0);
        chk("a4_cur_n", 32'(cur_n), 32'd4);
        chk("a4_clkout_sw", 32'(clkout), 32'd1);
        chk("a4_tick_sw", 32'(tick), 32'd1);
        req_a = 1'b0;
        exp_clk8  = 8'b10011001;
        exp_tick8 = 8'b00010001;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("n4_clkout_%0d", i), 32'(clkout), 32'(exp_clk8[7-i]));
            chk($sformatf("n4_tick_%0d", i), 32'(tick), 32'(exp_tick8[7-i]));
            chk($sformatf("n4_ack_a_%0d", i), 32'(ack_a), 32'd0);
        end

        // Illegal ratio from B: rejected with err, ratio unchanged
        req_b = 1'b1;
        n_b   = 4'd1;
        step();
        chk("b1_ack", 32'(ack_b), 32'd1);
        chk("b1_err", 32'(err), 32'd1);
        chk("b1_busy", 32'(busy), 32'd0);
        chk("b1_cur_n", 32'(cur_n), 32'd4);
        chk("b1_ack_a", 32'(ack_a), 32'd0);
        req_b = 1'b0;
        step();
        chk("b1_ack_end", 32'(ack_b), 32'd0);
        chk("b1_err_end", 32'(err), 32'd0);
        chk("b1_busy_end", 32'(busy), 32'd0);

        // req_a held across its ack: blocked in ack cycle, regranted after
        req_a = 1'b1;
        n_a   = 4'd9;
        step();
        chk("hold_busy_1", 32'(busy), 32'd1);
        chk("hold_noack_1", 32'(ack_a), 32'd0);
        step();
        chk("hold_ack", 32'(ack_a), 32'd1);
        chk("hold_cur_n", 32'(cur_n), 32'd9);
        chk("hold_busy_done", 32'(busy), 32'd0);
        chk("hold_tick", 32'(tick), 32'd1);
        chk("hold_clkout", 32'(clkout), 32'd1);
        step();
        chk("hold_no_regrant_busy", 32'(busy), 32'd0);
        chk("hold_no_regrant_ack", 32'(ack_a), 32'd0);
        step();
        chk("hold_regrant_busy", 32'(busy), 32'd1);
        chk("hold_regrant_ack", 32'(ack_a), 32'd0);

        // Reset while pending with pend_n=9: aborted, no ack
        rst   = 1'b1;
        req_a = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_cur_n", 32'(cur_n), 32'd5);
        chk("abort_clkout", 32'(clkout), 32'd0);
        chk("abort_tick", 32'(tick), 32'd0);
        chk("abort_ack_a", 32'(ack_a), 32'd0);
        chk("abort_ack_b", 32'(ack_b), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("abort_hold_ack_%0d", i), 32'(ack_a), 32'd0);
            chk($sformatf("abort_hold_busy_%0d", i), 32'(busy), 32'd0);
        end
        rst = 1'b0;
        step();
        chk("rel_clkout", 32'(clkout), 32'd1);
        chk("rel_cur_n", 32'(cur_n), 32'd5);
        chk("rel_ack_a", 32'(ack_a), 32'd0);
        chk("rel_busy", 32'(busy), 32'd0);
        chk("rel_tick", 32'(tick), 32'd0);

        // Simultaneous A(3) and B(7) after reset: A first, then B
        req_a = 1'b1;
        n_a   = 4'd3;
        req_b = 1'b1;
        n_b   = 4'd7;
        step();
        chk("rr_busy_a", 32'(busy), 32'd1);
        chk("rr_noack_a", 32'(ack_a), 32'd0);
        chk("rr_noack_b", 32'(ack_b), 32'd0);
        step();
        chk("rr_busy_a2", 32'(busy), 32'd1);
        step();
        chk("rr_busy_a3", 32'(busy), 32'd1);
        step();
        chk("rr_ack_a", 32'(ack_a), 32'd1);
        chk("rr_ack_b_lo", 32'(ack_b), 32'd0);
        chk("rr_err_a", 32'(err), 32'd0);
        chk("rr_cur_n_a", 32'(cur_n), 32'd3);
        chk("rr_busy_a_done", 32'(busy), 32'd0);
        req_a = 1'b0;
        step();
        chk("rr_busy_b", 32'(busy), 32'd1);
        chk("rr_ack_a_end", 32'(ack_a), 32'd0);
        chk("rr_ack_b_wait", 32'(ack_b), 32'd0);
        chk("rr_cur_n_hold", 32'(cur_n), 32'd3);
        step();
        chk("rr_busy_b2", 32'(busy), 32'd1);
        chk("rr_ack_b_wait2", 32'(ack_b), 32'd0);
        step();
        chk("rr_ack_b", 32'(ack_b), 32'd1);
        chk("rr_ack_a_lo", 32'(ack_a), 32'd0);
        chk("rr_err_b", 32'(err), 32'd0);
        chk("rr_cur_n_b", 32'(cur_n), 32'd7);
        chk("rr_busy_b_done", 32'(busy), 32'd0);
        req_b = 1'b0;
        step();
        chk("rr_ack_b_end", 32'(ack_b), 32'd0);
        chk("rr_busy_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
